sram_access_arbiter: RTL

Shares the single-port external SRAM, reached through `SRAM_Controller`, among the colour-space-conversion datapath's independent streams: the Y, U and V fetchers and the RGB writer.
- Each cycle, at most one read or write request is accepted, using round-robin priority.
- A bounded lock lets a requester issue back-to-back bursts, such as the 3-word RGB pixel-pair write.
- Read data is returned to the originating requester, with a tag that tracks the SRAM read latency.

---
 rtl/sram_access_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NREQ streams, with a
// bounded burst lock and a read-tag pipeline that routes data back to its requester.
module sram_access_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                     Clock_50,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          Req_i,
    input  logic [NREQ-1:0]          Req_we_i,
    input  logic [NREQ-1:0]          Req_lock_i,
    input  logic [NREQ*ADDR_W-1:0]   Req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   Req_wdata_i,
    output logic [NREQ-1:0]          Gnt_o,
    output logic [NREQ-1:0]          Rd_valid_o,
    output logic [DATA_W-1:0]        Rd_data_o,
    output logic                     Idle_o,
    input  logic                     SRAM_ready_i,
    output logic [ADDR_W-1:0]        SRAM_address_o,
    output logic [DATA_W-1:0]        SRAM_write_data_o,
    output logic                     SRAM_we_n_o,
    input  logic [DATA_W-1:0]        SRAM_read_data_i
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [NREQ-1:0]   w_gnt;
    logic              w_accept;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_sel_we;
    logic              w_sel_lock;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we_n;
    logic [READ_LAT:0] r_tag_vld;
    logic [IDX_W-1:0]  r_tag_idx [READ_LAT+1];
    logic [NREQ-1:0]   w_rd_valid;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] k);
        return ((int'(k) + 1) >= int'(NREQ)) ? '0 : k + IDX_W'(1);
    endfunction

    // State register
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; ready low freezes everything
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (SRAM_ready_i) begin
            case (r_state)
                ARB: begin
                    if (w_accept) begin
                        w_ptr_nxt = f_next(w_gnt_idx);
                        if (w_sel_lock && (MAX_LOCK > 1)) begin
                            w_state_nxt = LOCK;
                            w_owner_nxt = w_gnt_idx;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                LOCK: begin
                    if (!Req_i[r_owner]) begin
                        w_state_nxt = ARB;
                    end else if (!Req_lock_i[r_owner] ||
                                 ((int'(r_cnt) + 1) >= int'(MAX_LOCK))) begin
                        w_state_nxt = ARB;
                        w_ptr_nxt   = f_next(r_owner);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = ARB;
            endcase
        end
    end

    // Grant logic
    always_comb begin
        int unsigned v_k;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_accept  = 1'b0;
        v_k       = 0;
        if (!Reset && SRAM_ready_i) begin
            if (r_state == LOCK) begin
                if (Req_i[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                    w_gnt_idx      = r_owner;
                    w_accept       = 1'b1;
                end
            end else begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    v_k = int'(r_ptr) + i;
                    if (v_k >= NREQ) v_k = v_k - NREQ;
                    if (!w_accept && Req_i[v_k]) begin
                        w_gnt[v_k] = 1'b1;
                        w_gnt_idx  = IDX_W'(v_k);
                        w_accept   = 1'b1;
                    end
                end
            end
        end
    end

    // Mux the winning requester's command fields
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                w_sel_we    = Req_we_i[k];
                w_sel_lock  = Req_lock_i[k];
                w_sel_addr  = Req_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata = Req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we_n  <= 1'b1;
        end else if (w_accept) begin
            r_addr <= w_sel_addr;
            r_we_n <= ~w_sel_we;
            if (w_sel_we) r_wdata <= w_sel_wdata;
        end else begin
            r_we_n <= 1'b1;
        end
    end

    // Tag stage READ_LAT lines up with the cycle the SRAM returns read data
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_tag_vld <= '0;
            for (int unsigned i = 0; i <= READ_LAT; i++) r_tag_idx[i] <= '0;
        end else begin
            r_tag_vld[0] <= w_accept & ~w_sel_we;
            r_tag_idx[0] <= w_gnt_idx;
            for (int unsigned i = 1; i <= READ_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    always_comb begin
        w_rd_valid = '0;
        if (!Reset && r_tag_vld[READ_LAT]) w_rd_valid[r_tag_idx[READ_LAT]] = 1'b1;
    end

    assign Gnt_o             = w_gnt;
    assign Rd_valid_o        = w_rd_valid;
    assign Rd_data_o         = SRAM_read_data_i;
    assign Idle_o            = Reset | ((r_state == ARB) && (r_tag_vld == '0));
    assign SRAM_address_o    = r_addr;
    assign SRAM_write_data_o = r_wdata;
    assign SRAM_we_n_o       = r_we_n;

endmodule
